phase_seq_loop: RTL and testbench



---
 rtl/seq_pkg.sv | 13 +
 rtl/phase_seq_loop_if.sv | 16 +
 rtl/seq_iter_cnt.sv | 27 ++
 rtl/phase_seq_loop.sv | 75 +++++++
 tb/tb_phase_seq_loop.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: ALU-flow phase constants, counter opcodes and index-width helper shared by phase_seq_loop
package seq_pkg;
  localparam int PH_IDLE    = 0;
  localparam int PH_LOAD    = 1;
  localparam int PH_LOOP_LO = 2;
  localparam int PH_LOOP_HI = 3;
  localparam int PH_FIN     = 5;
  localparam int CNT_W_DEF  = 4;
  typedef enum logic [1:0] {CNT_KEEP, CNT_CLR, CNT_INC} cnt_op_e;
  function automatic int ph_idx_w(input int nph);
    return (nph > 1) ? $clog2(nph) : 1;
  endfunction
endpackage

// File: rtl/phase_seq_loop_if.sv
// phase_seq_loop_if: command/status bundle between the ALU decoder (master) and phase_seq_loop (slave)
interface phase_seq_loop_if import seq_pkg::*; #(
  parameter int NPH   = PH_FIN + 1,
  parameter int CNT_W = CNT_W_DEF
);
  logic             bgn;
  logic             end_req;
  logic             hold;
  logic [CNT_W-1:0] iter;
  logic [NPH-1:0]   fi;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  modport master(output bgn, end_req, hold, iter, input fi, cnt, busy, done);
  modport slave(input bgn, end_req, hold, iter, output fi, cnt, busy, done);
endinterface

// File: rtl/seq_iter_cnt.sv
// seq_iter_cnt: loop iteration counter with clear/ITER latch, increment and last-iteration compare
module seq_iter_cnt import seq_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cnt_op_e          op,
  input  logic [CNT_W-1:0] iter_in,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             iter_zero
);
  logic [CNT_W-1:0] iter_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt    <= '0;
      iter_q <= '0;
    end else if (op == CNT_CLR) begin
      cnt    <= '0;
      iter_q <= iter_in;
    end else if (op == CNT_INC) begin
      cnt    <= cnt + CNT_W'(1);
    end
  // one extra bit so ITER = 2^CNT_W-1 compares without wrapping
  assign last      = ({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, iter_q};
  assign iter_zero = iter_q == '0;
endmodule

// File: rtl/phase_seq_loop.sv
// phase_seq_loop: one-hot phase sequencer with repeated loop region, HOLD/END control and DONE/BUSY status
// Optional SEQ_BACK2BACK_EN: BGN in the final phase restarts at phase 1 with no idle cycle.
module phase_seq_loop import seq_pkg::*; #(
  parameter int NPH     = PH_FIN + 1,
  parameter int LOOP_LO = PH_LOOP_LO,
  parameter int LOOP_HI = PH_LOOP_HI,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  phase_seq_loop_if.slave  bus
);
  localparam int PW = ph_idx_w(NPH);
  localparam logic [PW-1:0] P_IDLE = PW'(PH_IDLE);
  localparam logic [PW-1:0] P_LOAD = PW'(PH_LOAD);
  localparam logic [PW-1:0] P_PRE  = PW'(LOOP_LO - 1);
  localparam logic [PW-1:0] P_LO   = PW'(LOOP_LO);
  localparam logic [PW-1:0] P_HI   = PW'(LOOP_HI);
  localparam logic [PW-1:0] P_POST = PW'(LOOP_HI + 1);
  localparam logic [PW-1:0] P_FIN  = PW'(NPH - 1);
  logic [PW-1:0] p, p_n, p_start;
  logic          done_q, done_n, last, iter_zero, b2b;
  cnt_op_e       op;
`ifdef SEQ_BACK2BACK_EN
  assign b2b = bus.bgn;
`else
  assign b2b = 1'b0;
`endif
  // a loop starting at phase 1 must already honour ITER=0 when leaving idle
  assign p_start = (LOOP_LO == 1 && bus.iter == '0) ? P_POST : P_LOAD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p      <= P_IDLE;
      done_q <= 1'b0;
    end else begin
      p      <= p_n;
      done_q <= done_n;
    end
  always_comb begin
    p_n    = p;
    op     = CNT_KEEP;
    done_n = 1'b0;
    if (p == P_IDLE) begin
      p_n = bus.bgn ? p_start : P_IDLE;
      op  = bus.bgn ? CNT_CLR : CNT_KEEP;
    end else if (bus.end_req && p != P_FIN) begin
      p_n = P_FIN;
    end else if (!bus.hold || bus.end_req) begin
      if (p == P_FIN) begin
        done_n = 1'b1;
        p_n    = b2b ? p_start : P_IDLE;
        op     = b2b ? CNT_CLR : CNT_KEEP;
      end else if (p == P_HI) begin
        op  = CNT_INC;
        p_n = last ? P_POST : P_LO;
      end else if (p == P_PRE) begin
        p_n = iter_zero ? P_POST : P_LO;
      end else begin
        p_n = p + PW'(1);
      end
    end
  end
  seq_iter_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .iter_in   (bus.iter),
    .cnt       (bus.cnt),
    .last      (last),
    .iter_zero (iter_zero)
  );
  assign bus.fi   = NPH'(1) << p;
  assign bus.busy = p != P_IDLE;
  assign bus.done = done_q;
endmodule

// File: tb/tb_phase_seq_loop.sv
// tb_phase_seq_loop: randomized self-checking bench; expected phase traces are built from the sequence rules as lists
module tb_phase_seq_loop;
  localparam int NPH = 6, LO = 2, HI = 3, CW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  phase_seq_loop_if #(.NPH(NPH), .CNT_W(CW)) bus ();
  phase_seq_loop #(.NPH(NPH), .LOOP_LO(LO), .LOOP_HI(HI), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic run_seq(input string tag, input int it, input int end_at, input int hold_at,
                         input int hold_len, input bit rnd);
    int q_p[$], q_c[$];
    int i, hc, nb, last, ce, ec, exp_len;
    bit dh, e, h, ended, fin;
    logic [NPH-1:0] ef;
    for (int p = 1; p < LO; p++) begin q_p.push_back(p); q_c.push_back(0); end
    for (int k = 0; k < it; k++)
      for (int p = LO; p <= HI; p++) begin q_p.push_back(p); q_c.push_back(k); end
    for (int p = HI + 1; p < NPH; p++) begin q_p.push_back(p); q_c.push_back(it); end
    last = q_p.size() - 1;
    bus.iter = CW'(it); bus.bgn = 1'b1; bus.hold = 1'b0; bus.end_req = 1'b0;
    @(posedge clk); #1;
    bus.bgn = 1'b0;
    i = 0; hc = 0; nb = 0; ce = 0; ended = 0; fin = 0;
    for (int g = 0; g < 400; g++) begin
      ef = '0; ef[q_p[i]] = 1'b1;
      ec = ended ? ce : q_c[i];
      n_chk += 4;
      if (bus.fi !== ef) begin n_fail++; $display("FAIL %s fi: got %b expected %b", tag, bus.fi, ef); end
      if (bus.cnt !== CW'(ec)) begin n_fail++; $display("FAIL %s cnt: got %0d expected %0d", tag, bus.cnt, ec); end
      if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy: got %b expected 1", tag, bus.busy); end
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done: got %b expected 0", tag, bus.done); end
      nb++;
      dh = (i == hold_at) && (hc < hold_len);
      e  = (i == end_at) && (i != last) && !dh;
      h  = dh || (e && hold_at == end_at) || (rnd && $urandom_range(3) == 0);
      if (dh) hc++;
      bus.hold = h; bus.end_req = e;
      bus.bgn = (rnd && i != last) ? 1'($urandom_range(1)) : 1'b0;
      if (rnd) bus.iter = CW'($urandom);
      @(posedge clk); #1;
      if (i == last && !h) begin fin = 1; break; end
      if (e) begin ended = 1; ce = q_c[i]; end
      i = e ? last : (h ? i : i + 1);
    end
    bus.hold = 1'b0; bus.end_req = 1'b0; bus.bgn = 1'b0;
    ec = ended ? ce : q_c[last];
    n_chk += 5;
    if (!fin) begin n_fail++; $display("FAIL %s timeout: got busy after 400 cycles expected idle", tag); end
    if (bus.fi !== NPH'(1)) begin n_fail++; $display("FAIL %s idle fi: got %b expected 000001", tag, bus.fi); end
    if (bus.cnt !== CW'(ec)) begin n_fail++; $display("FAIL %s final cnt: got %0d expected %0d", tag, bus.cnt, ec); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s idle busy: got %b expected 0", tag, bus.busy); end
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL %s done pulse: got %b expected 1", tag, bus.done); end
    if (end_at < 0 && hold_len == 0 && !rnd) begin
      exp_len = (it == 0) ? (NPH - 1) - (HI - LO + 1) : (NPH - 1) + (HI - LO + 1) * (it - 1);
      n_chk++;
      if (nb !== exp_len) begin n_fail++; $display("FAIL %s busy length: got %0d expected %0d", tag, nb, exp_len); end
    end
    @(posedge clk); #1;
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s done width: got %b expected 0", tag, bus.done); end
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && bus.busy === 1'b1; k++) begin @(posedge clk); #1; end
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s wait idle: got busy %b expected 0", tag, bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.bgn = 1'b0; bus.end_req = 1'b0; bus.hold = 1'b0; bus.iter = '0;
    repeat (2) @(posedge clk); #1;
    n_chk += 4;
    if (bus.fi !== NPH'(1)) begin n_fail++; $display("FAIL reset fi: got %b expected 000001", bus.fi); end
    if (bus.cnt !== '0) begin n_fail++; $display("FAIL reset cnt: got %0d expected 0", bus.cnt); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", bus.done); end
    rst_n = 1'b1;
    bus.iter = CW'(3); bus.bgn = 1'b1;
    @(posedge clk); #1;
    bus.bgn = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_chk += 2;
    if (bus.fi !== 6'b001000) begin n_fail++; $display("FAIL mid-seq fi: got %b expected 001000", bus.fi); end
    if (bus.cnt !== CW'(1)) begin n_fail++; $display("FAIL mid-seq cnt: got %0d expected 1", bus.cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_chk += 3;
    if (bus.fi !== NPH'(1)) begin n_fail++; $display("FAIL async reset fi: got %b expected 000001", bus.fi); end
    if (bus.cnt !== '0) begin n_fail++; $display("FAIL async reset cnt: got %0d expected 0", bus.cnt); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async reset busy: got %b expected 0", bus.busy); end
    #2 rst_n = 1'b1;
    bus.iter = '0; bus.bgn = 1'b1;
    @(posedge clk); #1;
    bus.bgn = 1'b0;
    n_chk++;
    if (bus.fi !== 6'b000010) begin n_fail++; $display("FAIL restart fi: got %b expected 000010", bus.fi); end
    wait_idle("restart");
  endtask

  task automatic test_idle_ignore();
    bus.bgn = 1'b0; bus.hold = 1'b1; bus.end_req = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_chk += 2;
    if (bus.fi !== NPH'(1)) begin n_fail++; $display("FAIL idle ignore fi: got %b expected 000001", bus.fi); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle ignore busy: got %b expected 0", bus.busy); end
    bus.hold = 1'b0; bus.end_req = 1'b0;
  endtask

  task automatic test_loop();
    run_seq("iter3", 3, -1, -1, 0, 0);
    run_seq("iter0", 0, -1, -1, 0, 0);
    run_seq("iter15", 15, -1, -1, 0, 0);
  endtask

  task automatic test_end();
    run_seq("end", 5, 3, -1, 0, 0);
  endtask

  task automatic test_hold();
    run_seq("hold_end", 2, 2, 2, 3, 0);
    run_seq("hold", 2, -1, 2, 3, 0);
  endtask

  task automatic test_random();
    int it, ea;
    for (int r = 0; r < 25; r++) begin
      it = (r == 0) ? 15 : $urandom_range(0, 15);
      ea = ($urandom_range(1) == 0) ? $urandom_range(0, 12) : -1;
      run_seq("rand", it, ea, -1, 0, 1);
    end
  endtask

  task automatic test_back_to_back();
    bus.iter = CW'(1); bus.bgn = 1'b1;
    @(posedge clk); #1;
    bus.bgn = 1'b0;
    repeat (4) @(posedge clk); #1;
    n_chk += 2;
    if (bus.fi !== 6'b100000) begin n_fail++; $display("FAIL b2b pre fi: got %b expected 100000", bus.fi); end
    if (bus.cnt !== CW'(1)) begin n_fail++; $display("FAIL b2b pre cnt: got %0d expected 1", bus.cnt); end
    bus.bgn = 1'b1; bus.iter = CW'(2);
    @(posedge clk); #1;
`ifdef SEQ_BACK2BACK_EN
    n_chk += 4;
    if (bus.fi !== 6'b000010) begin n_fail++; $display("FAIL b2b fi: got %b expected 000010", bus.fi); end
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b done: got %b expected 1", bus.done); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b busy: got %b expected 1", bus.busy); end
    if (bus.cnt !== '0) begin n_fail++; $display("FAIL b2b cnt: got %0d expected 0", bus.cnt); end
`else
    n_chk += 4;
    if (bus.fi !== 6'b000001) begin n_fail++; $display("FAIL b2b idle fi: got %b expected 000001", bus.fi); end
    if (bus.done !== 1'b1) begin n_fail++; $display("FAIL b2b done: got %b expected 1", bus.done); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b busy: got %b expected 0", bus.busy); end
    if (bus.cnt !== CW'(1)) begin n_fail++; $display("FAIL b2b idle cnt: got %0d expected 1", bus.cnt); end
    @(posedge clk); #1;
    n_chk += 2;
    if (bus.fi !== 6'b000010) begin n_fail++; $display("FAIL b2b restart fi: got %b expected 000010", bus.fi); end
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b restart done: got %b expected 0", bus.done); end
`endif
    bus.bgn = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (bus.fi !== 6'b000100) begin n_fail++; $display("FAIL b2b loop fi: got %b expected 000100", bus.fi); end
    wait_idle("b2b");
    n_chk++;
    if (bus.cnt !== CW'(2)) begin n_fail++; $display("FAIL b2b final cnt: got %0d expected 2", bus.cnt); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_loop();
    test_end();
    test_hold();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
